// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: accepts PCs, runs a single-outstanding imem request/grant/response, buffers {pc, instr} for decode.
// Aligned fetch reaches decode 3 cycles after accept, misaligned in 1; pc_ready drops while a fetch is in flight or the buffer is full.
module inst_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pc_mem_q    [FIFO_DEPTH];
  logic [31:0]     instr_mem_q [FIFO_DEPTH];
  logic            mis_mem_q   [FIFO_DEPTH];

  logic            accept, pop, push, push_mis;
  logic [31:0]     push_pc, push_instr;

  // Only IDLE may accept, so a free slot is always reserved for the fetch in flight.
  assign pc_ready = (state_q == IDLE) && (count_q < CW'(FIFO_DEPTH)) && !flush;
  assign accept   = pc_valid && pc_ready;
  assign pop      = (count_q != '0) && if_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    push       = 1'b0;
    push_pc    = addr_q;
    push_instr = imem_rdata;
    push_mis   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (pc[1:0] != 2'b00) begin
            push       = 1'b1;
            push_pc    = pc;
            push_instr = NOP_INSTR;
            push_mis   = 1'b1;
          end else begin
            addr_d  = pc;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (flush)         state_d = imem_gnt ? DROP : IDLE;
        else if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          push    = !flush;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      req_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
        mis_mem_q[i]   <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= push_pc;
        instr_mem_q[wr_ptr_q] <= push_instr;
        mis_mem_q[wr_ptr_q]   <= push_mis;
      end
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_valid    = (count_q != '0);
  assign if_pc       = pc_mem_q[rd_ptr_q];
  assign if_instr    = instr_mem_q[rd_ptr_q];
  assign if_misalign = mis_mem_q[rd_ptr_q];
  assign busy        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, hand sequences for full/flush/reset, then random traffic against a transaction-level model.
module tb_inst_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk, rst;
  logic [31:0] pc;
  logic        pc_valid, pc_ready, flush;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready, if_misalign, busy;
  logic [31:0] if_pc, if_instr;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_unit #(.FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_misalign(if_misalign),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic pv; logic [31:0] pc; logic fl, gnt, rv; logic [31:0] rd; logic ir;
    logic e_rdy, e_req; logic [31:0] e_addr; logic e_vld;
    logic [31:0] e_pc, e_instr; logic e_mis, e_busy;
  } vec_t;

  typedef struct { logic [31:0] pc, instr; logic mis; } ent_t;

  vec_t vecs[19];
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pv_i, input logic [31:0] pc_i, input logic fl_i,
                              input logic gnt_i, input logic rv_i, input logic [31:0] rd_i,
                              input logic ir_i, input logic rdy_e, input logic req_e,
                              input logic [31:0] addr_e, input logic vld_e, input logic [31:0] pc_e,
                              input logic [31:0] instr_e, input logic mis_e, input logic busy_e);
    vec_t v;
    v.pv = pv_i; v.pc = pc_i; v.fl = fl_i; v.gnt = gnt_i; v.rv = rv_i; v.rd = rd_i; v.ir = ir_i;
    v.e_rdy = rdy_e; v.e_req = req_e; v.e_addr = addr_e; v.e_vld = vld_e;
    v.e_pc = pc_e; v.e_instr = instr_e; v.e_mis = mis_e; v.e_busy = busy_e;
    return v;
  endfunction

  task automatic idle_inputs();
    pc_valid = 1'b0; pc = '0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
  endtask

  // Aligned fetch with grant and response at the earliest legal cycles; ends one negedge after the push.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    pc_valid = 1'b1; pc = a;
    @(negedge clk);
    pc_valid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d;
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

  // Transaction-level reference state: one outstanding fetch record plus the expected buffer contents.
  logic        txn, granted, dead;
  logic [31:0] txn_addr;
  logic        e_rdy, acc;

  initial begin
    rst = 1'b1; if_ready = 1'b0;
    idle_inputs();

    vecs[0]  = mk(1, 32'h0,   0, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    vecs[1]  = mk(0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 1, 32'h0,   0, 32'h0,   32'h0,        0, 1);
    vecs[2]  = mk(0, 32'h0,   0, 0, 1, 32'h00500093, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0,        0, 1);
    vecs[3]  = mk(1, 32'h6,   0, 0, 0, 32'h0,        1, 1, 0, 32'h0,   1, 32'h0,   32'h00500093, 0, 1);
    vecs[4]  = mk(0, 32'h0,   0, 0, 0, 32'h0,        0, 1, 0, 32'h0,   1, 32'h6,   NOP,          1, 1);
    vecs[5]  = mk(0, 32'h0,   0, 0, 0, 32'h0,        1, 1, 0, 32'h0,   1, 32'h6,   NOP,          1, 1);
    vecs[6]  = mk(1, 32'h40,  0, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    vecs[7]  = mk(0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 1, 32'h40,  0, 32'h0,   32'h0,        0, 1);
    vecs[8]  = mk(0, 32'h0,   1, 0, 0, 32'h0,        0, 0, 0, 32'h0,   0, 32'h0,   32'h0,        0, 1);
    vecs[9]  = mk(1, 32'h100, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,   0, 32'h0,   32'h0,        0, 1);
    vecs[10] = mk(1, 32'h100, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0,        0, 1);
    vecs[11] = mk(1, 32'h100, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    vecs[12] = mk(0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 1, 32'h100, 0, 32'h0,   32'h0,        0, 1);
    vecs[13] = mk(0, 32'h0,   0, 0, 1, 32'h11223344, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0,        0, 1);
    vecs[14] = mk(0, 32'h0,   0, 0, 0, 32'h0,        1, 1, 0, 32'h0,   1, 32'h100, 32'h11223344, 0, 1);
    vecs[15] = mk(0, 32'h0,   0, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    vecs[16] = mk(1, 32'h200, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    vecs[17] = mk(0, 32'h0,   1, 0, 0, 32'h0,        0, 0, 1, 32'h200, 0, 32'h0,   32'h0,        0, 1);
    vecs[18] = mk(0, 32'h0,   0, 0, 0, 32'h0,        0, 1, 0, 32'h0,   0, 32'h0,   32'h0,        0, 0);

    @(negedge clk); @(negedge clk);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_misalign", {31'b0, if_misalign}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      pc_valid = vecs[i].pv; pc = vecs[i].pc; flush = vecs[i].fl; imem_gnt = vecs[i].gnt;
      imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rd; if_ready = vecs[i].ir;
      #1;
      chk($sformatf("vec%0d_pc_ready", i), {31'b0, pc_ready}, {31'b0, vecs[i].e_rdy});
      chk($sformatf("vec%0d_imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("vec%0d_imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_vld});
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_if_instr", i), if_instr, vecs[i].e_instr);
        chk($sformatf("vec%0d_if_misalign", i), {31'b0, if_misalign}, {31'b0, vecs[i].e_mis});
      end
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
      @(negedge clk);
    end
    idle_inputs(); if_ready = 1'b0;

    // Fill to capacity under backpressure, then one pop reopens pc_ready; drain order checked.
    for (int k = 0; k < 4; k++) fetch(32'(4 * k), 32'hA0 + 32'(4 * k));
    pc_valid = 1'b1; pc = 32'h10;
    #1;
    chk("full_pc_ready", {31'b0, pc_ready}, 32'h0);
    chk("full_head_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0; pc_valid = 1'b0;
    #1;
    chk("after_pop_pc_ready", {31'b0, pc_ready}, 32'h1);
    for (int k = 1; k < 4; k++) begin
      if_ready = 1'b1;
      #1;
      chk($sformatf("drain%0d_pc", k), if_pc, 32'(4 * k));
      chk($sformatf("drain%0d_instr", k), if_instr, 32'hA0 + 32'(4 * k));
      @(negedge clk);
    end
    if_ready = 1'b0;
    #1;
    chk("drained_if_valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);

    // Flush coinciding with a push and a pop on a 3-entry buffer.
    for (int k = 0; k < 3; k++) fetch(32'h20 + 32'(4 * k), 32'(k + 1));
    pc_valid = 1'b1; pc = 32'h30;
    @(negedge clk);
    pc_valid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4; if_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    idle_inputs(); if_ready = 1'b0;
    #1;
    chk("flush3_if_valid", {31'b0, if_valid}, 32'h0);
    chk("flush3_busy", {31'b0, busy}, 32'h0);
    chk("flush3_pc_ready", {31'b0, pc_ready}, 32'h1);
    @(negedge clk);

    // Asynchronous reset while waiting for a response.
    fetch(32'h60, 32'h55);
    pc_valid = 1'b1; pc = 32'h80;
    @(negedge clk);
    pc_valid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #1;
    chk("wait_busy", {31'b0, busy}, 32'h1);
    chk("wait_imem_addr", imem_addr, 32'h80);
    #1 rst = 1'b1;
    #1;
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("arst_if_pc", if_pc, 32'h0);
    chk("arst_if_instr", if_instr, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("late_rvalid_if_valid", {31'b0, if_valid}, 32'h0);
    chk("late_rvalid_busy", {31'b0, busy}, 32'h0);

    // Random traffic against the transaction model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    txn = 1'b0; granted = 1'b0; dead = 1'b0; txn_addr = '0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      pc_valid = ($urandom % 3) != 0;
      pc = $urandom;
      if (($urandom % 5) != 0) pc[1:0] = 2'b00;
      flush = ($urandom % 16) == 0;
      if_ready = ($urandom % 3) != 0;
      imem_gnt = txn && !granted && (($urandom % 2) == 1);
      if (txn && granted) imem_rvalid = ($urandom % 2) == 1;
      else                imem_rvalid = ($urandom % 20) == 0;
      imem_rdata = $urandom;
      #1;
      e_rdy = !txn && (q.size() < DEPTH) && !flush;
      chk("rnd_pc_ready", {31'b0, pc_ready}, {31'b0, e_rdy});
      chk("rnd_imem_req", {31'b0, imem_req}, {31'b0, txn && !granted});
      if (txn && !granted) chk("rnd_imem_addr", imem_addr, txn_addr);
      chk("rnd_if_valid", {31'b0, if_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("rnd_if_pc", if_pc, q[0].pc);
        chk("rnd_if_instr", if_instr, q[0].instr);
        chk("rnd_if_misalign", {31'b0, if_misalign}, {31'b0, q[0].mis});
      end
      chk("rnd_busy", {31'b0, busy}, {31'b0, txn || (q.size() != 0)});

      acc = pc_valid && e_rdy;
      if (flush) begin
        q.delete();
        if (txn) begin
          if (!granted) begin
            if (imem_gnt) begin granted = 1'b1; dead = 1'b1; end
            else txn = 1'b0;
          end else if (imem_rvalid) txn = 1'b0;
          else dead = 1'b1;
        end
      end else begin
        if (q.size() != 0 && if_ready) void'(q.pop_front());
        if (txn && !granted && imem_gnt) granted = 1'b1;
        else if (txn && granted && imem_rvalid) begin
          if (!dead) q.push_back('{txn_addr, imem_rdata, 1'b0});
          txn = 1'b0;
        end
        if (acc) begin
          if (pc[1:0] != 2'b00) q.push_back('{pc, NOP, 1'b1});
          else begin txn = 1'b1; granted = 1'b0; dead = 1'b0; txn_addr = pc; end
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
